// File: rtl/mem_port_arbiter.sv
// Shares one memory between an instruction-fetch port (read only) and a data load/store port,
// sequencing read latency, write completion or timeout, and a one-cycle response per transaction.
module mem_port_arbiter #(
    parameter int WORD_SIZE     = 32,
    parameter int READ_LATENCY  = 1,
    parameter int WRITE_TIMEOUT = 64,
    parameter bit ROUND_ROBIN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_ready,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] if_rdata,
    output logic                 if_err,
    input  logic                 d_req,
    input  logic [1:0]           d_size,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ready,
    output logic                 d_valid,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 d_err,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [1:0]           mem_write,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic [WORD_SIZE-1:0] mem_rdata,
    input  logic                 mem_done,
    input  logic                 mem_error,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, READ_WAIT, WRITE_WAIT, RESPOND} state_t;

    localparam logic [7:0] READ_LAST  = 8'(READ_LATENCY - 1);
    localparam logic [7:0] WRITE_LAST = 8'(WRITE_TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       last_grant;   // 0 = IF, 1 = D; also identifies the owner of the open transaction
    logic       grant_if;
    logic       grant_d;

    // Grants exist only in IDLE and are suppressed while reset is asserted.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state == IDLE && rst) begin
            if (if_req && d_req) begin
                if (ROUND_ROBIN && last_grant)
                    grant_if = 1'b1;
                else
                    grant_d = 1'b1;
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    assign if_ready = grant_if;
    assign d_ready  = grant_d;
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b0;
            mem_addr   <= '0;
            mem_write  <= 2'b00;
            mem_wdata  <= '0;
            if_valid   <= 1'b0;
            if_rdata   <= '0;
            if_err     <= 1'b0;
            d_valid    <= 1'b0;
            d_rdata    <= '0;
            d_err      <= 1'b0;
        end else begin
            if_valid <= 1'b0;
            d_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_d) begin
                        mem_addr   <= d_addr;
                        mem_write  <= d_size;
                        mem_wdata  <= d_wdata;
                        last_grant <= 1'b1;
                        cnt        <= '0;
                        state      <= (d_size == 2'b00) ? READ_WAIT : WRITE_WAIT;
                    end else if (grant_if) begin
                        mem_addr   <= if_addr;
                        mem_write  <= 2'b00;
                        last_grant <= 1'b0;
                        cnt        <= '0;
                        state      <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (cnt == READ_LAST) begin
                        if (last_grant) begin
                            d_rdata <= mem_rdata;
                            d_err   <= mem_error;
                            d_valid <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_err   <= mem_error;
                            if_valid <= 1'b1;
                        end
                        state <= RESPOND;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WRITE_WAIT: begin
                    // A completion on the final allowed cycle still counts as a normal finish.
                    if (mem_done) begin
                        d_err     <= mem_error;
                        d_valid   <= 1'b1;
                        mem_write <= 2'b00;
                        state     <= RESPOND;
                    end else if (cnt == WRITE_LAST) begin
                        d_err     <= 1'b1;
                        d_valid   <= 1'b1;
                        mem_write <= 2'b00;
                        state     <= RESPOND;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                RESPOND: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: reset, grant table, directed transaction table, tie alternation,
// reset abort, then randomized traffic against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int RL = 1;
    localparam int WT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic        if_valid;
    logic [31:0] if_rdata;
    logic        if_err;
    logic        d_req;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ready;
    logic        d_valid;
    logic [31:0] d_rdata;
    logic        d_err;
    logic [31:0] mem_addr;
    logic [1:0]  mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_done;
    logic        mem_error;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .WORD_SIZE(32), .READ_LATENCY(RL), .WRITE_TIMEOUT(WT), .ROUND_ROBIN(1'b1)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_valid(if_valid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_valid(d_valid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_write(mem_write), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done), .mem_error(mem_error), .busy(busy)
    );

    // Memory contents seen by the arbiter: a fixed word at 0, an address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0) return 32'h0050_0093;
        return {~a[15:0], a[15:0]} ^ 32'h5A00_00C3;
    endfunction

    assign mem_rdata = mem_word(mem_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; mem_done = 1'b0; mem_error = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit ir; bit dr; bit eir; bit edr;
    } rdy_t;

    typedef struct {
        bit          is_d;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          done_at;
        bit          merr;
        int          exp_lat;
        bit          exp_err;
        logic [31:0] exp_rdata;
        int          exp_mw;
    } txn_t;

    rdy_t rtbl[4];
    txn_t tbl[8];

    initial begin
        int          lat, mw, got, both, vcnt;
        int          ord[4];
        logic [31:0] last_d_rd;
        int          acc_t, resp_t, done_at;
        bit          cur_d, cur_wr, cur_err, last_d, p_if, p_d, idle, in_txn, wwait, e_ifr, e_dr;
        logic [1:0]  cur_size;
        logic [31:0] cur_addr, m_if_rd, m_d_rd;
        logic        exp_err;

        rtbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
        rtbl[1] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rtbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1};
        rtbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1};

        tbl[0] = '{1'b0, 2'b00, 32'h0000_0000, 32'h0,          0, 1'b0, 2, 1'b0, 32'h0050_0093, 0};
        tbl[1] = '{1'b1, 2'b11, 32'h0000_0010, 32'hDEAD_BEEF,  3, 1'b0, 4, 1'b0, 32'h0, 3};
        tbl[2] = '{1'b1, 2'b11, 32'h0000_0014, 32'hCAFE_F00D,  0, 1'b0, 9, 1'b1, 32'h0, 8};
        tbl[3] = '{1'b1, 2'b00, 32'h0000_0003, 32'h0,          0, 1'b1, 2, 1'b1, mem_word(32'h3), 0};
        tbl[4] = '{1'b0, 2'b00, 32'h0000_0040, 32'h0,          0, 1'b0, 2, 1'b0, mem_word(32'h40), 0};
        tbl[5] = '{1'b1, 2'b01, 32'h0000_0021, 32'h0000_00A5,  1, 1'b1, 2, 1'b1, 32'h0, 1};
        tbl[6] = '{1'b1, 2'b10, 32'h0000_0022, 32'h0000_1234,  8, 1'b0, 9, 1'b0, 32'h0, 8};
        tbl[7] = '{1'b1, 2'b00, 32'h0000_0100, 32'h0,          0, 1'b0, 2, 1'b0, mem_word(32'h100), 0};

        if_addr = 32'h0; d_addr = 32'h0; d_size = 2'b00; d_wdata = 32'h0;
        mem_done = 1'b0; mem_error = 1'b0;

        // Reset state, with both ports requesting
        rst = 1'b0; if_req = 1'b1; d_req = 1'b1; d_size = 2'b11;
        repeat (2) @(posedge clk); #1;
        chk("rst_ready", 32'({if_ready, d_ready}), 32'd0);
        chk("rst_valid", 32'({if_valid, d_valid}), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_write", 32'(mem_write), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_rdata", if_rdata | d_rdata, 32'd0);
        do_reset();

        // Combinational grant in IDLE, last grant = IF; requests withdrawn before the edge
        for (int i = 0; i < 4; i++) begin
            if_req = rtbl[i].ir; d_req = rtbl[i].dr; d_size = 2'b00;
            #1;
            chk("grant_tbl", 32'({if_ready, d_ready}), 32'({rtbl[i].eir, rtbl[i].edr}));
        end
        if_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1;

        // Directed transactions
        last_d_rd = 32'h0;
        for (int i = 0; i < 8; i++) begin
            if_req = !tbl[i].is_d; if_addr = tbl[i].addr;
            d_req = tbl[i].is_d; d_size = tbl[i].size; d_addr = tbl[i].addr; d_wdata = tbl[i].wdata;
            mem_error = tbl[i].merr; mem_done = 1'b0;
            #1;
            chk("txn_ready", 32'(tbl[i].is_d ? d_ready : if_ready), 32'd1);
            lat = 0; mw = 0;
            for (int n = 1; n <= 20 && lat == 0; n++) begin
                @(posedge clk); #1;
                if_req = 1'b0; d_req = 1'b0;
                mem_done = (n == tbl[i].done_at);
                #1;
                if (n == 1) begin
                    chk("txn_mem_addr", mem_addr, tbl[i].addr);
                    if (tbl[i].size != 2'b00) chk("txn_mem_wdata", mem_wdata, tbl[i].wdata);
                end
                if (mem_write != 2'b00) mw++;
                if (if_valid || d_valid) lat = n;
            end
            mem_done = 1'b0;
            chk("txn_latency", 32'(lat), 32'(tbl[i].exp_lat));
            chk("txn_port", 32'({if_valid, d_valid}), tbl[i].is_d ? 32'd1 : 32'd2);
            chk("txn_err", 32'(tbl[i].is_d ? d_err : if_err), 32'(tbl[i].exp_err));
            chk("txn_write_cycles", 32'(mw), 32'(tbl[i].exp_mw));
            chk("txn_mem_write_end", 32'(mem_write), 32'd0);
            if (!tbl[i].is_d) begin
                chk("txn_if_rdata", if_rdata, tbl[i].exp_rdata);
            end else if (tbl[i].size == 2'b00) begin
                chk("txn_d_rdata", d_rdata, tbl[i].exp_rdata);
                last_d_rd = tbl[i].exp_rdata;
            end else begin
                chk("txn_d_rdata_hold", d_rdata, last_d_rd);
            end
            @(posedge clk); #1;
            chk("txn_pulse_end", 32'({if_valid, d_valid, busy}), 32'd0);
        end

        // Ties after reset alternate D, IF, D, IF
        do_reset();
        if_req = 1'b1; if_addr = 32'h200; d_req = 1'b1; d_size = 2'b00; d_addr = 32'h100;
        got = 0; both = 0;
        for (int n = 0; n < 40 && got < 4; n++) begin
            #1;
            if (if_ready && d_ready) both++;
            if (d_ready) begin ord[got] = 1; got++; end
            else if (if_ready) begin ord[got] = 0; got++; end
            @(posedge clk); #1;
        end
        if_req = 1'b0; d_req = 1'b0;
        chk("tie_grants", 32'(got), 32'd4);
        chk("tie_exclusive", 32'(both), 32'd0);
        if (got == 4) chk("tie_order", {ord[0][7:0], ord[1][7:0], ord[2][7:0], ord[3][7:0]},
                          32'h01_00_01_00);
        repeat (4) @(posedge clk); #1;

        // Reset in the middle of a write aborts it without a response
        do_reset();
        d_req = 1'b1; d_size = 2'b11; d_addr = 32'h80; d_wdata = 32'h1111_2222;
        @(posedge clk); #1;
        d_req = 1'b0;
        repeat (2) @(posedge clk); #1;
        chk("abort_pre_write", 32'(mem_write), 32'd3);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("abort_mem_write", 32'(mem_write), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        @(posedge clk); #3 rst = 1'b1;
        vcnt = 0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (d_valid || busy) vcnt++;
        end
        chk("abort_no_valid", 32'(vcnt), 32'd0);

        // Randomized traffic against a transaction-level model
        do_reset();
        acc_t = -100; resp_t = -100; done_at = -100; last_d = 1'b0; p_if = 1'b0; p_d = 1'b0;
        cur_d = 1'b0; cur_wr = 1'b0; cur_err = 1'b0; cur_size = 2'b00; cur_addr = 32'h0;
        m_if_rd = 32'h0; m_d_rd = 32'h0; exp_err = 1'b0;
        for (int t = 0; t < 800; t++) begin
            if (!p_if && $urandom_range(2) == 0) begin p_if = 1'b1; if_addr = $urandom; end
            else if (p_if && $urandom_range(15) == 0) p_if = 1'b0;
            if (!p_d && $urandom_range(2) == 0) begin
                p_d = 1'b1; d_size = 2'($urandom_range(3)); d_addr = $urandom; d_wdata = $urandom;
            end else if (p_d && $urandom_range(15) == 0) p_d = 1'b0;
            if_req = p_if; d_req = p_d;

            idle   = (t > resp_t);
            in_txn = (t > acc_t) && (t <= resp_t);
            wwait  = cur_wr && (t > acc_t) && (t < resp_t);
            mem_done  = wwait ? (t == done_at) : ($urandom_range(3) == 0);
            mem_error = in_txn ? cur_err : 1'($urandom_range(1));
            e_dr  = idle && p_d && !(p_if && last_d);
            e_ifr = idle && p_if && !(p_d && !last_d);
            if (t == resp_t) begin
                if (!cur_d) m_if_rd = mem_word(cur_addr);
                else if (!cur_wr) m_d_rd = mem_word(cur_addr);
                exp_err = (cur_wr && done_at > acc_t + WT) ? 1'b1 : cur_err;
            end
            #1;
            chk("rnd_if_ready", 32'(if_ready), 32'(e_ifr));
            chk("rnd_d_ready", 32'(d_ready), 32'(e_dr));
            chk("rnd_if_valid", 32'(if_valid), 32'(t == resp_t && !cur_d));
            chk("rnd_d_valid", 32'(d_valid), 32'(t == resp_t && cur_d));
            chk("rnd_busy", 32'(busy), 32'(in_txn));
            chk("rnd_mem_write", 32'(mem_write), 32'(wwait ? cur_size : 2'b00));
            chk("rnd_if_rdata", if_rdata, m_if_rd);
            chk("rnd_d_rdata", d_rdata, m_d_rd);
            if (t == resp_t) chk("rnd_err", 32'(cur_d ? d_err : if_err), 32'(exp_err));
            if (in_txn) chk("rnd_mem_addr", mem_addr, cur_addr);

            if (e_ifr || e_dr) begin
                acc_t    = t;
                cur_d    = e_dr;
                cur_addr = e_dr ? d_addr : if_addr;
                cur_size = e_dr ? d_size : 2'b00;
                cur_wr   = e_dr && (d_size != 2'b00);
                cur_err  = ($urandom_range(3) == 0);
                if (cur_wr) begin
                    done_at = t + int'($urandom_range(WT + 3, 1));
                    resp_t  = (done_at <= t + WT) ? done_at + 1 : t + WT + 1;
                end else begin
                    resp_t = t + RL + 1;
                end
                last_d = e_dr;
                if (e_dr) p_d = 1'b0; else p_if = 1'b0;
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
